// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg
// Shared definitions for the ROM-to-decoder byte streamer.
//   state_t : controller state encoding (also exported on the debug port)
//   NL, NUL : ASCII newline and string terminator
package rom_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_INJECT = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] NL  = 8'h0A;
    localparam logic [7:0] NUL = 8'h00;

endpackage

// File: rtl/rom_stream_ctrl.sv
// rom_stream_ctrl
// Streams a NUL-terminated ASCII string out of a synchronous ROM, one byte
// per cycle, towards a command decoder instantiated next to this block.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start             : begin a stream at address 0 (only honoured in IDLE)
//   stall             : downstream not ready; blocks issue of new ROM reads
//   rom_en, rom_addr  : ROM read strobe and address
//   rom_data          : ROM byte, valid the cycle after rom_en
//   char_out          : byte forwarded to the decoder
//   char_valid        : char_out valid this cycle
//   busy              : high in every state except IDLE
//   done              : one-cycle pulse at the end of a stream
//   byte_count        : bytes delivered with char_valid, held until next start
//   state_dbg         : current controller state, for observation only
//
// Configuration
//   ROM_STREAM_NL_INJECT_EN : when defined, a stream whose last forwarded byte
//   is not a newline is terminated with one synthesized 0x0A.
//
// Handshake: char_valid is a one-cycle qualifier with no ready return.
// Flow control is done upstream of the ROM: stall only suppresses new reads,
// so a read issued before stall rose is still delivered one cycle later and
// the decoder must be able to absorb that single in-flight byte.
module rom_stream_ctrl
    import rom_stream_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int ROM_DEPTH    = 65536,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stall,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    output logic [7:0]            char_out,
    output logic                  char_valid,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   byte_count,
    output state_t                state_dbg
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROM_DEPTH - 1);
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST =
        DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    // With no drain cycles configured the stream end goes straight to DONE.
    localparam state_t AFTER_STREAM = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  pend_q, pend_d;    // read issued last cycle
    logic                  last_q, last_d;    // read of LAST_ADDR issued
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [7:0]            char_q, char_d;
    logic                  valid_q, valid_d;
    logic [DCW-1:0]        drain_q, drain_d;
    logic                  armed_q;           // start ignored on first edge after reset
    logic                  issue;
    logic                  stream_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
            char_q  <= '0;
            valid_q <= 1'b0;
            drain_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            count_q <= count_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            drain_q <= drain_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pend_d     = 1'b0;
        last_d     = last_q;
        count_d    = count_q;
        char_d     = char_q;
        valid_d    = 1'b0;
        drain_d    = drain_q;
        issue      = 1'b0;
        stream_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && armed_q) begin
                    state_d = ST_STREAM;
                    addr_d  = '0;
                    count_d = '0;
                    last_d  = 1'b0;
                    drain_d = '0;
                end
            end

            ST_STREAM: begin
                issue = !stall && !last_q;
                if (issue) begin
                    pend_d = 1'b1;
                    // The address saturates at the top of the ROM; last_q
                    // then blocks any further issue.
                    if (addr_q == LAST_ADDR) begin
                        last_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end

                if (pend_q) begin
                    if (rom_data == NUL) begin
                        stream_end = 1'b1;
                    end else begin
                        char_d  = rom_data;
                        valid_d = 1'b1;
                        count_d = count_q + 1'b1;
                        // Once last_q is set, the only outstanding read is
                        // the one for LAST_ADDR.
                        if (last_q) begin
                            stream_end = 1'b1;
                        end
                    end
                end

                if (stream_end) begin
                    // A read issued in this same cycle is dropped here.
                    pend_d  = 1'b0;
                    drain_d = '0;
`ifdef ROM_STREAM_NL_INJECT_EN
                    // Decision uses the post-update byte/count, since the
                    // final byte may be forwarded on this very edge.
                    if ((count_d != '0) && (char_d != NL)) begin
                        state_d = ST_INJECT;
                    end else begin
                        state_d = AFTER_STREAM;
                    end
`else
                    state_d = AFTER_STREAM;
`endif
                end
            end

`ifdef ROM_STREAM_NL_INJECT_EN
            ST_INJECT: begin
                if (!stall) begin
                    char_d  = NL;
                    valid_d = 1'b1;
                    count_d = count_q + 1'b1;
                    drain_d = '0;
                    state_d = AFTER_STREAM;
                end
            end
`endif

            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end

            ST_DONE: begin
                drain_d = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rom_en     = issue;
    assign rom_addr   = addr_q;
    assign char_out   = char_q;
    assign char_valid = valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign byte_count = count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// tb_rom_stream_ctrl
// Directed bench for rom_stream_ctrl. Instance u_big uses default parameters
// (full ROM); instance u_small uses ROM_DEPTH=4 to exercise the top-of-ROM
// stop. Expectations follow ROM_STREAM_NL_INJECT_EN when it is defined.
module tb_rom_stream_ctrl;
    import rom_stream_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (defaults) ----------------
    logic        start_a, stall_a;
    logic        rom_en_a;
    logic [15:0] rom_addr_a;
    logic [7:0]  rom_data_a = 8'h00;
    logic [7:0]  char_out_a;
    logic        char_valid_a, busy_a, done_a;
    logic [16:0] byte_count_a;
    state_t      state_a;

    rom_stream_ctrl u_big (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stall(stall_a),
        .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .char_out(char_out_a), .char_valid(char_valid_a), .busy(busy_a),
        .done(done_a), .byte_count(byte_count_a), .state_dbg(state_a)
    );

    // ---------------- DUT B (4-byte ROM) ----------------
    logic        start_b, stall_b;
    logic        rom_en_b;
    logic [3:0]  rom_addr_b;
    logic [7:0]  rom_data_b = 8'h00;
    logic [7:0]  char_out_b;
    logic        char_valid_b, busy_b, done_b;
    logic [4:0]  byte_count_b;
    state_t      state_b;

    rom_stream_ctrl #(.ADDR_WIDTH(4), .ROM_DEPTH(4), .DRAIN_CYCLES(2)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stall(stall_b),
        .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .char_out(char_out_b), .char_valid(char_valid_b), .busy(busy_b),
        .done(done_b), .byte_count(byte_count_b), .state_dbg(state_b)
    );

    // ---------------- ROM models (synchronous read) ----------------
    logic [7:0] rom_a [0:15];
    logic [7:0] rom_b [0:3];

    always @(posedge clk) begin
        if (rom_en_a) rom_data_a <= (rom_addr_a < 16'd16) ? rom_a[rom_addr_a[3:0]] : 8'hEE;
        if (rom_en_b) rom_data_b <= (rom_addr_b < 4'd4) ? rom_b[rom_addr_b[1:0]] : 8'hEE;
    end

    // ---------------- monitors ----------------
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    int first_a, last_a, done_a_n, done_a_cyc, done_b_n, bad_b;

    always @(negedge clk) begin
        if (char_valid_a) begin
            if (got_a.size() == 0) first_a = cyc;
            got_a.push_back(char_out_a);
            last_a = cyc;
        end
        if (done_a) begin
            done_a_n++;
            done_a_cyc = cyc;
        end
        if (char_valid_b) got_b.push_back(char_out_b);
        if (done_b) done_b_n++;
        if (rom_en_b && (rom_addr_b > 4'd3)) bad_b++;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_exp(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic check_q(input string tag, input logic [7:0] g[$]);
        check({tag, "_len"}, g.size(), exp_q.size());
        for (int i = 0; i < g.size() && i < exp_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), g[i], exp_q[i]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_rom_a(input string s);
        for (int i = 0; i < 16; i++) rom_a[i] = (i < s.len()) ? s[i] : 8'h00;
    endtask

    task automatic clear_mon();
        got_a.delete();
        got_b.delete();
        done_a_n = 0;
        done_b_n = 0;
        bad_b    = 0;
    endtask

    task automatic pulse_start_a(output int sc);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 sc = cyc;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (done_a_n == 0 && n < 200) begin
            @(negedge clk);
            #1 n++;
        end
        check({tag, "_done_seen"}, (done_a_n > 0), 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int sc;
        int n;
        int dirs[$];
        int vals[$];
        int acc;
        int dir;

        rst_n   = 1'b0;
        start_a = 1'b0;
        stall_a = 1'b0;
        start_b = 1'b0;
        stall_b = 1'b0;
        clear_mon();
        load_rom_a("");
        rom_b[0] = "R"; rom_b[1] = "1"; rom_b[2] = 8'h0A; rom_b[3] = "L";

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rom_en", rom_en_a, 0);
        check("rst_rom_addr", rom_addr_a, 0);
        check("rst_char_out", char_out_a, 0);
        check("rst_char_valid", char_valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_byte_count", byte_count_a, 0);
        check("rst_state", state_a, ST_IDLE);
        check("rst_busy_b", busy_b, 0);

        // Start on the first edge after reset release is not accepted
        rst_n   = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        check("early_start_busy", busy_a, 0);
        start_a = 1'b0;
        repeat (2) @(negedge clk);

        // Basic stream, plus a second start mid-stream that must be ignored
        clear_mon();
        load_rom_a("L68\nR48\n");
        pulse_start_a(sc);
        repeat (2) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("basic");
        repeat (4) @(negedge clk);
        load_exp("L68\nR48\n");
        check_q("basic", got_a);
        check("basic_consecutive", last_a - first_a, 7);
        check("basic_byte_count", byte_count_a, 8);
        check("basic_done_once", done_a_n, 1);
        check("basic_done_after_last", done_a_cyc - last_a, 3);
        check("basic_idle_after", busy_a, 0);

        // Decoder view of the forwarded bytes: direction L=0/R=1, decimal value
        acc = 0;
        dir = 0;
        foreach (got_a[i]) begin
            if (got_a[i] == "L") dir = 0;
            else if (got_a[i] == "R") dir = 1;
            else if (got_a[i] == 8'h0A) begin
                dirs.push_back(dir);
                vals.push_back(acc);
                acc = 0;
            end else acc = acc * 10 + (got_a[i] - "0");
        end
        check("dec_count", dirs.size(), 2);
        if (dirs.size() == 2) begin
            check("dec0_dir", dirs[0], 0);
            check("dec0_val", vals[0], 68);
            check("dec1_dir", dirs[1], 1);
            check("dec1_val", vals[1], 48);
        end

        // Top-of-ROM stop on the 4-byte instance
        clear_mon();
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (done_b_n == 0 && n < 100) begin
            @(negedge clk);
            #1 n++;
        end
        check("depth_done_seen", (done_b_n > 0), 1);
        repeat (4) @(negedge clk);
`ifdef ROM_STREAM_NL_INJECT_EN
        load_exp("R1\nL\n");
        check("depth_byte_count", byte_count_b, 5);
`else
        load_exp("R1\nL");
        check("depth_byte_count", byte_count_b, 4);
`endif
        check_q("depth", got_b);
        check("depth_no_overread", bad_b, 0);
        check("depth_done_once", done_b_n, 1);

        // Stall for 3 cycles after the first byte
        clear_mon();
        load_rom_a("R5\n");
        pulse_start_a(sc);
        n = 0;
        while (!char_valid_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_first_seen", char_valid_a, 1);
        stall_a = 1'b1;
        #1 check("stall_rom_en_c1", rom_en_a, 0);
        @(negedge clk);
        #1 check("stall_rom_en_c2", rom_en_a, 0);
        @(negedge clk);
        #1 check("stall_rom_en_c3", rom_en_a, 0);
        @(negedge clk);
        stall_a = 1'b0;
        #1 check("stall_inflight_only", got_a.size(), 2);
        wait_done_a("stall");
        repeat (3) @(negedge clk);
        load_exp("R5\n");
        check_q("stall", got_a);
        check("stall_byte_count", byte_count_a, 3);

        // Empty string: NUL at address 0
        clear_mon();
        load_rom_a("");
        pulse_start_a(sc);
        wait_done_a("empty");
        repeat (3) @(negedge clk);
        check("empty_pulses", got_a.size(), 0);
        check("empty_byte_count", byte_count_a, 0);
        check("empty_done_latency", done_a_cyc - sc, 2 + 2);
        check("empty_done_once", done_a_n, 1);

        // Reset mid-stream, then a fresh stream
        clear_mon();
        load_rom_a("L68\nR48\n");
        pulse_start_a(sc);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rom_en", rom_en_a, 0);
        check("midrst_rom_addr", rom_addr_a, 0);
        check("midrst_char_out", char_out_a, 0);
        check("midrst_char_valid", char_valid_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_byte_count", byte_count_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 clear_mon();
        repeat (10) @(negedge clk);
        check("midrst_quiet", got_a.size(), 0);
        pulse_start_a(sc);
        wait_done_a("restart");
        repeat (3) @(negedge clk);
        load_exp("L68\nR48\n");
        check_q("restart", got_a);
        check("restart_byte_count", byte_count_a, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_stream_ctrl.md
ROM_STREAM_CTRL -- requirements
Module: rom_stream_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, ROM address width.
REQ-002 Parameter ROM_DEPTH, default 65536, highest readable address is ROM_DEPTH-1.
REQ-003 Parameter DRAIN_CYCLES, default 2, idle cycles after the last byte before done.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin streaming from address 0; ignored unless IDLE.
REQ-007 stall  in  1  downstream not ready; blocks new ROM reads.
REQ-008 rom_en  out  1  ROM read strobe.
REQ-009 rom_addr  out  ADDR_WIDTH  ROM read address.
REQ-010 rom_data  in  8  ROM byte, valid the cycle after rom_en.
REQ-011 char_out  out  8  ASCII byte to decoder.
REQ-012 char_valid  out  1  char_out valid this cycle.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at end of stream.
REQ-015 byte_count  out  ADDR_WIDTH+1  bytes delivered with char_valid, held until next start.

Function
REQ-016 States: IDLE, STREAM, INJECT, DRAIN, DONE.
REQ-017 IDLE->STREAM on start; rom_addr cleared to 0, byte_count cleared.
REQ-018 STREAM: rom_en=1 exactly when stall=0 and no stop condition seen; rom_addr increments after each issued read.
REQ-019 Stall gates issue only; a read already issued is always delivered one cycle later, regardless of stall.
REQ-020 Returned byte != 0x00 -> char_out=rom_data, char_valid=1 for one cycle, byte_count+1.
REQ-021 Returned byte == 0x00 -> stream ends; byte not forwarded; any read issued in the same cycle is discarded (no char_valid).
REQ-022 Read of address ROM_DEPTH-1 issued -> no further reads; stream ends after that byte returns.
REQ-023 Stream end -> INJECT if enabled (REQ-031) and required, else DRAIN.
REQ-024 DRAIN counts DRAIN_CYCLES cycles, char_valid=0, then DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 start during any state other than IDLE has no effect.
REQ-027 rom_addr never exceeds ROM_DEPTH-1; no wrap.

Reset
REQ-028 rst_n low asynchronously forces IDLE; rom_en, rom_addr, char_out, char_valid, busy, done, byte_count and drain counter all 0.
REQ-029 Reset mid-stream abandons the in-flight read; no char_valid after rst_n rises until a new start.
REQ-030 First start is accepted no earlier than the second rising edge after rst_n rises.

Configuration
REQ-031 Macro ROM_STREAM_NL_INJECT_EN defined: if byte_count>0 and last forwarded byte != 0x0A, INJECT emits char_out=0x0A, char_valid=1 once, waiting while stall=1, counted in byte_count; then DRAIN.
REQ-032 Macro undefined: INJECT state absent, stream end goes directly to DRAIN; no synthesized bytes.

Structure
REQ-033 Package rom_stream_pkg holds the state enumeration and ASCII constants NL (0x0A) and NUL (0x00).
REQ-034 No sub-module; drain counter and address counter are inline. The decoder is instantiated alongside this block, not inside it.

Verification
REQ-035 ROM "L68\nR48\n" + 0x00, stall=0 -> 8 char_valid pulses on consecutive cycles, bytes in order, byte_count=8, done once, decoder emits (0,68) then (1,48).
REQ-036 ROM_DEPTH=4, ROM "R1\nL", no NUL -> with macro 5 pulses, last 0x0A, byte_count=5; without macro 4 pulses, byte_count=4; no read beyond address 3.
REQ-037 ROM "R5\n"+0x00, stall high for 3 cycles after the first byte -> rom_en low during stall, exactly one in-flight byte delivered, total 3 pulses, no loss or duplication.
REQ-038 ROM starting with 0x00 -> zero char_valid, no injected NL, byte_count=0, done after DRAIN_CYCLES.
REQ-039 start pulsed again mid-stream -> ignored; rst_n pulsed low mid-stream -> all outputs 0 immediately, no char_valid until next start, fresh stream from address 0.
